// File: rtl/sec_arb_pkg.sv
// Shared types for the security-engine arbiter: response error codes and FSM states.
package sec_arb_pkg;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_DENIED  = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

endpackage

// File: rtl/sec_rr_arbiter.sv
// Round-robin picker: first requester after last_grant (modulo N) wins; one-hot grant plus index.
module sec_rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   always_comb begin
      int unsigned c;
      logic        found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= N; i++) begin
         c = int'(last_grant) + i;
         if (c >= N) c = c - N;
         if (!found && req[c]) begin
            found  = 1'b1;
            gnt[c] = 1'b1;
            idx    = IW'(c);
         end
      end
   end

endmodule

// File: rtl/sec_engine_arbiter.sv
// Round-robin, one-transaction-at-a-time arbiter sharing a crypto engine among NUM_CH clients.
// Optional engine watchdog enabled by defining SEC_ARB_TIMEOUT_EN.
module sec_engine_arbiter #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned DATA_W  = 256,
   parameter int unsigned OP_W    = 2,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          req_valid,
   output logic [NUM_CH-1:0]          req_ready,
   input  logic [NUM_CH*OP_W-1:0]     req_op,
   input  logic [NUM_CH*DATA_W-1:0]   req_data,
   output logic [NUM_CH-1:0]          resp_valid,
   input  logic [NUM_CH-1:0]          resp_ready,
   output logic [DATA_W-1:0]          resp_data,
   output logic [1:0]                 resp_err,
   output logic                       eng_valid,
   input  logic                       eng_ready,
   output logic [OP_W-1:0]            eng_op,
   output logic [DATA_W-1:0]          eng_data,
   input  logic                       eng_done,
   input  logic [DATA_W-1:0]          eng_result,
   output logic                       eng_abort,
   input  logic                       cfg_we,
   input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
   input  logic [2**OP_W-1:0]         cfg_perm,
   input  logic                       cfg_lock,
   output logic                       locked,
   output logic                       busy,
   output logic [7:0]                 err_count
);
   import sec_arb_pkg::*;

   localparam int unsigned IW = $clog2(NUM_CH);
   localparam int unsigned PW = 2**OP_W;

   arb_state_t         state;
   logic [PW-1:0]      perm [NUM_CH];
   logic [IW-1:0]      last_grant;
   logic [IW-1:0]      gidx;
   logic [IW-1:0]      ch_q;
   logic [NUM_CH-1:0]  gnt;
   logic [NUM_CH-1:0]  ch_oh;
   logic [OP_W-1:0]    win_op;
   logic [DATA_W-1:0]  win_data;
   logic               wd_expire;

   sec_rr_arbiter #(.N(NUM_CH), .IW(IW)) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .gnt        (gnt),
      .idx        (gidx)
   );

   assign req_ready = (state == IDLE) ? gnt : '0;
   assign busy      = (state != IDLE);
   assign win_op    = req_op[gidx*OP_W +: OP_W];
   assign win_data  = req_data[gidx*DATA_W +: DATA_W];

   // Write is gated by the lock value from before this edge, so write+lock together still lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         locked <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) perm[i] <= '0;
      end else begin
         if (cfg_we && !locked && (32'(cfg_ch) < NUM_CH)) perm[cfg_ch] <= cfg_perm;
         if (cfg_lock) locked <= 1'b1;
      end
   end

`ifdef SEC_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT);
   logic [CNT_W-1:0] wd_cnt;

   always_ff @(posedge clk) begin
      if (rst || state != WAIT) wd_cnt <= '0;
      else                      wd_cnt <= wd_cnt + CNT_W'(1);
   end

   assign wd_expire = (state == WAIT) && (wd_cnt == CNT_W'(TIMEOUT - 1)) && !eng_done;
`else
   assign wd_expire = 1'b0;
`endif
   assign eng_abort = wd_expire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= IW'(NUM_CH - 1);
         ch_q       <= '0;
         ch_oh      <= '0;
         eng_op     <= '0;
         eng_data   <= '0;
         eng_valid  <= 1'b0;
         resp_valid <= '0;
         resp_data  <= '0;
         resp_err   <= ERR_OK;
         err_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|gnt) begin
                  ch_q     <= gidx;
                  ch_oh    <= gnt;
                  eng_op   <= win_op;
                  eng_data <= win_data;
                  if (perm[gidx][win_op]) begin
                     eng_valid <= 1'b1;
                     state     <= ISSUE;
                  end else begin
                     resp_valid <= gnt;
                     resp_data  <= '0;
                     resp_err   <= ERR_DENIED;
                     state      <= RESP;
                  end
               end
            end
            ISSUE: begin
               if (eng_ready) begin
                  eng_valid <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (eng_done) begin
                  resp_valid <= ch_oh;
                  resp_data  <= eng_result;
                  resp_err   <= ERR_OK;
                  state      <= RESP;
               end else if (wd_expire) begin
                  resp_valid <= ch_oh;
                  resp_data  <= '0;
                  resp_err   <= ERR_TIMEOUT;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (|(resp_valid & resp_ready)) begin
                  resp_valid <= '0;
                  last_grant <= ch_q;
                  if (resp_err != ERR_OK && err_count != 8'hFF) err_count <= err_count + 8'd1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sec_engine_arbiter.sv
// Bench for sec_engine_arbiter: table vectors, hand sequences and a randomized phase against a reference model.
// Watchdog checks follow SEC_ARB_TIMEOUT_EN, matching the RTL build.
module tb_sec_engine_arbiter;

   localparam int unsigned NCH = 4;
   localparam int unsigned DW  = 256;
   localparam int unsigned OW  = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [3:0]      req_valid = '0;
   logic [3:0]      req_ready;
   logic [7:0]      req_op = '0;
   logic [1023:0]   req_data = '0;
   logic [3:0]      resp_valid;
   logic [3:0]      resp_ready = '0;
   logic [255:0]    resp_data;
   logic [1:0]      resp_err;
   logic            eng_valid;
   logic            eng_ready = 1'b0;
   logic [1:0]      eng_op;
   logic [255:0]    eng_data;
   logic            eng_done = 1'b0;
   logic [255:0]    eng_result = '0;
   logic            eng_abort;
   logic            cfg_we = 1'b0;
   logic [1:0]      cfg_ch = '0;
   logic [3:0]      cfg_perm = '0;
   logic            cfg_lock = 1'b0;
   logic            locked;
   logic            busy;
   logic [7:0]      err_count;

   sec_engine_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .OP_W(OW), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
      .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_op(eng_op), .eng_data(eng_data),
      .eng_done(eng_done), .eng_result(eng_result), .eng_abort(eng_abort),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_perm(cfg_perm), .cfg_lock(cfg_lock),
      .locked(locked), .busy(busy), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [3:0] mperm [4];
   bit         mlock;
   int         mlast;
   int         mcnt;

   typedef struct {
      int           ch;
      logic [3:0]   perm;
      logic [1:0]   op;
      logic [255:0] data;
      logic [1:0]   err;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [255:0] eng_fn(input logic [1:0] op, input logic [255:0] d);
      return (d ^ {256{1'b1}}) + 256'(op);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0; resp_ready = '0; eng_ready = 1'b0; eng_done = 1'b0;
      cfg_we = 1'b0; cfg_lock = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) mperm[i] = '0;
      mlock = 1'b0; mlast = 3; mcnt = 0;
   endtask

   task automatic cfg(input int ch, input logic [3:0] p, input bit we, input bit lk);
      cfg_we = we; cfg_ch = 2'(ch); cfg_perm = p; cfg_lock = lk;
      @(posedge clk); #1;
      cfg_we = 1'b0; cfg_lock = 1'b0;
      if (we && !mlock) mperm[ch] = p;
      if (lk) mlock = 1'b1;
   endtask

   task automatic set_ch(input int c, input logic [1:0] op, input logic [255:0] d);
      req_valid[c] = 1'b1;
      req_op[c*2 +: 2] = op;
      req_data[c*256 +: 256] = d;
   endtask

   // Runs one transaction from IDLE with requests already driven; ends one cycle after the response handshake.
   task automatic run_txn(input logic [3:0] eg, input logic [1:0] ee, input logic [1:0] eop,
                          input logic [255:0] edata, input logic [255:0] eres,
                          input int rd, input int dd, input int rr, input bit drop);
      logic [255:0] exp_resp;
      #1;
      check("req_ready", req_ready, eg);
      check("eng_idle", eng_valid, 0);
      @(posedge clk); #1;
      if (drop) req_valid = '0;
      if (ee == 2'b01) begin
         exp_resp = '0;
         check("deny_no_eng", eng_valid, 0);
      end else begin
         check("eng_valid", eng_valid, 1);
         check("eng_op", eng_op, eop);
         check("eng_data", eng_data, edata);
         repeat (rd) begin
            @(posedge clk); #1;
            check("eng_hold", eng_valid, 1);
         end
         eng_ready = 1'b1;
         @(posedge clk); #1;
         eng_ready = 1'b0;
         check("eng_drop", eng_valid, 0);
         repeat (dd) begin
            check("early_resp", resp_valid, 0);
            @(posedge clk); #1;
         end
         eng_done = 1'b1; eng_result = eres;
         @(posedge clk); #1;
         eng_done = 1'b0; eng_result = '0;
         exp_resp = eres;
      end
      check("resp_valid", resp_valid, eg);
      check("resp_err", resp_err, ee);
      check("resp_data", resp_data, exp_resp);
      check("busy_resp", busy, 1);
      repeat (rr) begin
         @(posedge clk); #1;
         check("resp_hold", resp_valid, eg);
      end
      resp_ready = '1;
      #1 check("no_grant_in_resp", req_ready, 0);
      @(posedge clk); #1;
      resp_ready = '0;
      if (ee != 2'b00 && mcnt < 255) mcnt++;
      check("resp_clr", resp_valid, 0);
      check("err_count", err_count, mcnt);
      check("busy_idle", busy, 0);
   endtask

   task automatic to_wait();
      req_valid = '0;
      set_ch(2, 2'd1, 256'h77);
      #1 check("wd_grant", req_ready, 4'b0100);
      @(posedge clk); #1;
      req_valid = '0;
      check("wd_issue", eng_valid, 1);
      eng_ready = 1'b1;
      @(posedge clk); #1;
      eng_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got stuck expected completion");
      $fatal(1);
   end

   initial begin
      logic [255:0] d [4];
      tbl[0] = '{0, 4'b0001, 2'd0, 256'h1111, 2'b00};
      tbl[1] = '{1, 4'b1000, 2'd3, 256'hDEAD_BEEF, 2'b00};
      tbl[2] = '{3, 4'b0111, 2'd3, 256'h3333, 2'b01};
      tbl[3] = '{2, 4'b0100, 2'd1, 256'h4444, 2'b01};
      tbl[4] = '{3, 4'b1111, 2'd2, {8{32'hCAFE_F00D}}, 2'b00};
      tbl[5] = '{1, 4'b0000, 2'd0, 256'h6666, 2'b01};

      do_reset();
      // Reset values
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_eng_valid", eng_valid, 0);
      check("rst_eng_abort", eng_abort, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_err_count", err_count, 0);
      check("rst_locked", locked, 0);
      check("rst_busy", busy, 0);

      // Denial straight after reset
      set_ch(0, 2'd1, 256'hABC);
      run_txn(4'b0001, 2'b01, 2'd1, 256'hABC, '0, 0, 0, 1, 1);

      // Normal transaction, engine answers three cycles after eng_ready
      cfg(2, 4'b0010, 1, 0);
      set_ch(2, 2'd1, 256'hA5);
      run_txn(4'b0100, 2'b00, 2'd1, 256'hA5, 256'h5A, 0, 2, 0, 1);

      // Table vectors
      foreach (tbl[i]) begin
         cfg(tbl[i].ch, tbl[i].perm, 1, 0);
         req_valid = '0;
         set_ch(tbl[i].ch, tbl[i].op, tbl[i].data);
         run_txn(4'(1 << tbl[i].ch), tbl[i].err, tbl[i].op, tbl[i].data,
                 eng_fn(tbl[i].op, tbl[i].data), 1, i % 3, i % 2, 1);
      end

      // Fairness: everyone requesting continuously
      do_reset();
      for (int c = 0; c < 4; c++) cfg(c, 4'hF, 1, 0);
      for (int c = 0; c < 4; c++) begin
         d[c] = 256'(32'h100 * (c + 1));
         set_ch(c, 2'd0, d[c]);
      end
      for (int k = 0; k < 5; k++)
         run_txn(4'(1 << (k % 4)), 2'b00, 2'd0, d[k % 4], eng_fn(2'd0, d[k % 4]), 0, 1, 0, 0);
      req_valid = '0;
      mlast = 0;

      // A request raised while busy and dropped before IDLE is never latched
      cfg(0, 4'h0, 1, 0);
      set_ch(0, 2'd0, 256'h1);
      @(posedge clk); #1;
      req_valid = 4'b1000;
      check("drop_resp", resp_valid, 4'b0001);
      check("drop_no_ready", req_ready, 0);
      @(posedge clk); #1;
      req_valid = '0;
      resp_ready = '1;
      @(posedge clk); #1;
      resp_ready = '0;
      mcnt++;
      check("drop_idle_ready", req_ready, 0);
      @(posedge clk); #1;
      check("drop_not_latched", busy, 0);

      // Randomized phase against the reference model
      do_reset();
      for (int it = 0; it < 40; it++) begin
         logic [3:0]   vm;
         logic [1:0]   ops [4];
         logic [255:0] ds [4];
         int           w;
         logic [1:0]   ee;
         if ($urandom_range(0, 2) == 0) cfg($urandom_range(0, 3), 4'($urandom), 1, 0);
         vm = 4'($urandom_range(1, 15));
         req_valid = '0;
         for (int c = 0; c < 4; c++) begin
            ops[c] = 2'($urandom);
            ds[c]  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (vm[c]) set_ch(c, ops[c], ds[c]);
         end
         w = -1;
         for (int k = 1; k <= 4; k++)
            if (w < 0 && vm[(mlast + k) % 4]) w = (mlast + k) % 4;
         ee = mperm[w][ops[w]] ? 2'b00 : 2'b01;
         run_txn(4'(1 << w), ee, ops[w], ds[w], eng_fn(ops[w], ds[w]),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1);
         mlast = w;
      end

      // Saturation of err_count
      cfg(0, 4'h0, 1, 0);
      while (mcnt < 255 + 2) begin
         req_valid = '0;
         set_ch(0, 2'd2, 256'h9);
         run_txn(4'b0001, 2'b01, 2'd2, 256'h9, '0, 0, 0, 0, 1);
         if (mcnt == 255) mcnt = 257;
      end
      check("err_sat", err_count, 8'hFF);

      // Lock behaviour, including write and lock in the same cycle
      do_reset();
      cfg(2, 4'b0010, 1, 0);
      cfg(1, 4'b0010, 1, 1);
      check("locked_set", locked, 1);
      cfg(2, 4'b0000, 1, 0);
      cfg(0, 4'b0000, 0, 1);
      check("locked_hold", locked, 1);
      set_ch(2, 2'd1, 256'h22);
      run_txn(4'b0100, 2'b00, 2'd1, 256'h22, eng_fn(2'd1, 256'h22), 0, 0, 0, 1);
      set_ch(1, 2'd1, 256'h11);
      run_txn(4'b0010, 2'b00, 2'd1, 256'h11, eng_fn(2'd1, 256'h11), 0, 0, 0, 1);
      set_ch(1, 2'd0, 256'h10);
      run_txn(4'b0010, 2'b01, 2'd0, 256'h10, '0, 0, 0, 0, 1);
      check("locked_still", locked, 1);

`ifdef SEC_ARB_TIMEOUT_EN
      begin
         int first;
         to_wait();
         first = -1;
         for (int k = 0; k < 20; k++) begin
            if (first < 0 && eng_abort) first = k;
            if (first >= 0) break;
            @(posedge clk); #1;
         end
         check("abort_delay", 32'(first), 32'd7);
         @(posedge clk); #1;
         check("abort_pulse", eng_abort, 0);
         check("to_resp_valid", resp_valid, 4'b0100);
         check("to_resp_err", resp_err, 2'b10);
         check("to_resp_data", resp_data, 0);
         resp_ready = '1;
         @(posedge clk); #1;
         resp_ready = '0;
         mcnt++;
         check("to_err_count", err_count, mcnt);
         to_wait();
      end
`else
      begin
         int bad;
         to_wait();
         bad = 0;
         repeat (40) begin
            @(posedge clk); #1;
            if (!busy || resp_valid != 4'b0000 || eng_abort) bad++;
         end
         check("hang_busy", 32'(bad), 32'd0);
      end
`endif

      // Reset in WAIT: immediate return to IDLE, no response, fresh grant to ch0
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) mperm[i] = '0;
      mlock = 1'b0; mlast = 3; mcnt = 0;
      check("wrst_busy", busy, 0);
      check("wrst_resp", resp_valid, 0);
      check("wrst_abort", eng_abort, 0);
      check("wrst_eng", eng_valid, 0);
      check("wrst_locked", locked, 0);
      eng_done = 1'b1; eng_result = 256'hF00;
      @(posedge clk); #1;
      eng_done = 1'b0;
      check("stray_done_busy", busy, 0);
      check("stray_done_resp", resp_valid, 0);
      set_ch(0, 2'd3, 256'h5);
      run_txn(4'b0001, 2'b01, 2'd3, 256'h5, '0, 0, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sec_engine_arbiter.md
# sec_engine_arbiter

Parametrised successor to the single-client security wrapper. It lets NUM_CH independent clients share one crypto engine (hash or cipher) through a round-robin, one-transaction-at-a-time arbiter. Each channel has a per-operation permission mask that can be locked after boot. An optional watchdog aborts hung engine operations. It sits between the bus-side client ports and the engine's start/done interface inside the security subsystem.

## Interface
Parameters:
- NUM_CH, 4: number of client channels (2..16).
- DATA_W, 256: request/result payload width.
- OP_W, 2: operation code width; each channel has 2**OP_W permission bits.
- TIMEOUT, 1024: watchdog limit in cycles (≥2); used only with the macro.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_CH  per-channel request.
- req_ready  out  NUM_CH  one-hot accept; at most one bit high.
- req_op  in  NUM_CH*OP_W  flattened op codes; channel c at [c*OP_W +: OP_W].
- req_data  in  NUM_CH*DATA_W  flattened payloads.
- resp_valid  out  NUM_CH  one-hot response strobe.
- resp_ready  in  NUM_CH  per-channel response accept.
- resp_data  out  DATA_W  result; shared by all channels.
- resp_err  out  2  00 OK, 01 DENIED, 10 TIMEOUT.
- eng_valid  out  1  engine start request.
- eng_ready  in  1  engine accepts start.
- eng_op  out  OP_W  latched op.
- eng_data  out  DATA_W  latched payload.
- eng_done  in  1  one-cycle completion strobe.
- eng_result  in  DATA_W  result, valid with eng_done.
- eng_abort  out  1  one-cycle abort pulse on timeout.
- cfg_we  in  1  permission write strobe.
- cfg_ch  in  $clog2(NUM_CH)  target channel.
- cfg_perm  in  2**OP_W  permission bits to write.
- cfg_lock  in  1  sets the sticky lock.
- locked  out  1  lock status.
- busy  out  1  FSM state is not IDLE.
- err_count  out  8  saturating count of DENIED and TIMEOUT responses.

## Operation
- Permission table: NUM_CH × 2**OP_W bits.
  - Resets to all-zero (deny all).
  - A cfg_we write replaces the row for cfg_ch.
  - cfg_we is ignored while locked=1.
  - cfg_lock sets locked. Only rst clears it.
  - A write and a lock in the same cycle: the write takes effect, then the table locks.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The winner is the first channel with req_valid set, searching from last_grant+1 modulo NUM_CH.
  - req_ready for the winner is asserted combinationally.
  - On accept, latch the channel, op and data.
  - If the permission bit for that op is 1, go to ISSUE. Otherwise go to RESP with error DENIED and resp_data=0; the engine is never touched.
- ISSUE: eng_valid=1 with the latched op and data. On eng_ready, go to WAIT.
- WAIT:
  - On eng_done, capture eng_result with error OK and go to RESP.
  - eng_done outside WAIT is ignored.
- RESP:
  - resp_valid for the latched channel is held, together with resp_data and resp_err, until resp_ready.
  - Then: last_grant is set to that channel, err_count is incremented if the error was non-zero (saturating at 255), and the FSM returns to IDLE.
- Reset:
  - Outputs: req_ready, resp_valid, eng_valid and eng_abort are 0; resp_data, resp_err and err_count are 0; locked and busy are 0.
  - Internal: last_grant is NUM_CH-1, so channel 0 wins first.
  - rst mid-transaction returns the FSM to IDLE immediately. No response is issued and eng_abort is not pulsed.

## Timing
- Accept at cycle T (IDLE) → eng_valid at T+1.
- eng_done at cycle D → resp_valid at D+1.
- DENIED: resp_valid at T+1.
- Minimum back-to-back spacing: resp_ready accept at R → next req_ready no earlier than R+1.
- Fairness: with all channels requesting continuously, grants rotate 0,1,…,NUM_CH-1.
- A request that drops req_valid before acceptance is not latched.

## Configuration
- SEC_ARB_TIMEOUT_EN defined:
  - A cycle counter starts at 0 on entry to WAIT.
  - If it reaches TIMEOUT-1 without eng_done, eng_abort pulses for one cycle and the FSM goes to RESP with TIMEOUT and resp_data=0.
  - If eng_done arrives in that same cycle, eng_done wins.
- SEC_ARB_TIMEOUT_EN not defined: no counter; eng_abort is tied to 0; WAIT waits indefinitely.

## Structure
- Shared package sec_arb_pkg holds:
  - resp_err encodings: ERR_OK, ERR_DENIED, ERR_TIMEOUT.
  - FSM state enum: arb_state_t.
- One sub-module, sec_rr_arbiter: parametrised round-robin picker. Inputs: request vector and last_grant. Outputs: one-hot grant and index.

## Test plan
- Permission denial: after reset, ch0 sends op 1 → resp_valid[0] one cycle after accept, resp_err=01, eng_valid never asserted, err_count=1.
- Normal transaction: write cfg_ch=2, cfg_perm=4'b0010; ch2 sends op 1 with data 0xA5; engine returns 0x5A three cycles after eng_ready → resp_data=0x5A, resp_err=00, on resp_valid[2] only.
- Round-robin fairness: all 4 channels permitted and requesting continuously → grant order 0,1,2,3,0.
- Lock: set cfg_lock, then write ch2's permissions to 0 → write ignored, ch2 op 1 still OK, locked=1 until rst.
- Watchdog (macro on, TIMEOUT=8): engine never sends done → eng_abort pulses 7 cycles after WAIT entry, resp_err=10. With the macro off, busy stays 1 indefinitely.
- Reset during WAIT: assert rst → next cycle busy=0, no resp_valid, and a fresh request from ch0 is granted.
